execute_forward_unit: RTL and testbench
=======================================

Name: execute_forward_unit

Overview:
- Parametrised operand-forwarding and hazard unit for the execute stage.
- Keeps a DEPTH-entry history window of results leaving EX, and supplies forwarded SrcA/SrcB from the youngest matching in-flight producer.
- Detects load-use hazards against a single outstanding multi-cycle load and asserts stall until the load data returns.
- Owns the register-file writeback of entries retiring from the window.

Parameters:
XLEN, 32, data width
REG_AW, 5, register address width
DEPTH, 3, forwarding window entries (>=1); SEL_W = clog2(DEPTH+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill the instruction currently leaving EX (not captured)
ex_valid  in  1  instruction leaving EX this cycle
ex_regwrite  in  1  it writes rd
ex_is_load  in  1  it is a load; result arrives later on ld_resp
ex_rd  in  REG_AW  destination register
ex_result  in  XLEN  ALU result (ignored for loads)
ld_resp_valid  in  1  load data return strobe
ld_resp_data  in  XLEN  load data
id_rs1, id_rs2  in  REG_AW  source registers of the instruction entering EX
rs1_data, rs2_data  in  XLEN  register-file read data
src_a, src_b  out  XLEN  forwarded operands
fwd_sel_a, fwd_sel_b  out  SEL_W  0 = regfile, k = window entry k-1
stall  out  1  freeze upstream stages
wb_en  out  1  regfile write enable
wb_rd  out  REG_AW  regfile write address
wb_data  out  XLEN  regfile write data
stall_count  out  16  saturating count of stalled cycles

Behaviour:
- Window entry fields: valid, rd, data, ready. Entry 0 is youngest.
- Reset (async, rst_n=0): all entries valid=0, ready=1. pend=0. stall_count=0. Outputs wb_en=0, stall=0, fwd_sel=0.
- advance = ~stall.
- On advance, entries shift toward DEPTH-1. Entry 0 is loaded with {ex_valid & ex_regwrite & ~flush & (ex_rd!=0), ex_rd, ex_result, ~ex_is_load}.
- On stall: the window holds. Upstream holds the ex_* and id_* inputs stable.
- Retire: when advance and entry DEPTH-1 is valid, wb_en=1 with wb_rd/wb_data = that entry, combinationally in the same cycle. An entry never retires while not ready.
- Pending load: at most one entry has ready=0 (pend=1).
  - ld_resp_valid while pend writes ld_resp_data into that entry and sets ready=1. This happens in the same clock as any shift; the entry tracks its new position.
  - ld_resp_valid with pend=0 is ignored.
- Forward match, per source s:
  - A source register of 0 always selects the regfile; x0 is never forwarded.
  - Otherwise select the lowest-index entry with valid and rd==s. fwd_sel = index+1; no match gives 0.
  - Data comes from that entry. If the entry is the pending load and ld_resp_valid is high this cycle, ld_resp_data is bypassed and no stall is raised.
- stall=1 if any of:
  - (a) either source's selected entry has ready=0 and no same-cycle ld_resp;
  - (b) ex_valid & ex_is_load & ~flush while pend=1 and no ld_resp this cycle (second load);
  - (c) the pending entry sits at DEPTH-1 and no ld_resp this cycle.
- All outputs except stall_count are combinational from state and inputs; zero-cycle forwarding latency.
- stall_count increments every cycle stall=1 and saturates at 16'hFFFF.
- flush never clears already-captured entries.
- rst_n assertion mid-load drops the pending load; later ld_resp is ignored.

Test Plan:
1. DEPTH=3. Capture add x5=0x10, then id_rs1=x5 next cycle -> fwd_sel_a=1, src_a=0x10, stall=0.
2. x5 written at entries 0 (0x22) and 2 (0x11); id_rs2=x5 -> fwd_sel_b=1, src_b=0x22 (youngest wins).
3. Load x7 captured, then id_rs1=x7 with no ld_resp for 2 cycles -> stall=1 for 2 cycles, stall_count=2. ld_resp_valid with data 0xABCD on cycle 3 -> src_a=0xABCD, stall=0 that cycle.
4. Writes to x0 with rs1=x0 -> fwd_sel_a=0, src_a=rs1_data. On retirement, wb_en is never raised for the x0 bubble.
5. Pending load reaches entry 2 without a response -> stall=1 and wb_en=0. ld_resp arrives -> next advance retires it with wb_en=1, wb_rd=load rd, wb_data=response.
6. Second load while one is pending -> stall until ld_resp. Flush with ex_valid=1 -> bubble captured, no forward from that rd. Assert rst_n low mid-stall -> all outputs are the reset values immediately.

Source files
------------

// File: rtl/execute_forward_unit.sv
// Execute-stage operand forwarding and hazard unit: a DEPTH-entry result window
// feeds SrcA/SrcB, tracks one outstanding load, and retires the oldest entry to the regfile.
module execute_forward_unit #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_regwrite,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              ld_resp_valid,
    input  logic [XLEN-1:0]   ld_resp_data,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic [XLEN-1:0]   src_a,
    output logic [XLEN-1:0]   src_b,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
    output logic              stall,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic [15:0]       stall_count
);

    logic [DEPTH-1:0]  win_valid;
    logic [DEPTH-1:0]  win_ready;
    logic [REG_AW-1:0] win_rd   [DEPTH];
    logic [XLEN-1:0]   win_data [DEPTH];
    logic [XLEN-1:0]   upd_data [DEPTH];

    logic pend;
    logic advance;
    logic a_wait;
    logic b_wait;
    logic cap_valid;
    logic cap_load;

    assign pend      = ~&win_ready;
    assign cap_valid = ex_valid & ex_regwrite & ~flush & (ex_rd != '0);
    assign cap_load  = ex_valid & ex_is_load & ~flush;

    // Window contents as seen this cycle, with a returning load already merged in.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            upd_data[i] = (~win_ready[i] & ld_resp_valid) ? ld_resp_data : win_data[i];
        end
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        src_a     = rs1_data;
        src_b     = rs2_data;
        a_wait    = 1'b0;
        b_wait    = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (id_rs1 != '0 && win_valid[i] && win_rd[i] == id_rs1) begin
                fwd_sel_a = SEL_W'(i + 1);
                src_a     = upd_data[i];
                a_wait    = ~win_ready[i] & ~ld_resp_valid;
            end
            if (id_rs2 != '0 && win_valid[i] && win_rd[i] == id_rs2) begin
                fwd_sel_b = SEL_W'(i + 1);
                src_b     = upd_data[i];
                b_wait    = ~win_ready[i] & ~ld_resp_valid;
            end
        end
    end

    assign stall = a_wait | b_wait
                 | (cap_load & pend & ~ld_resp_valid)
                 | (~win_ready[DEPTH-1] & ~ld_resp_valid);
    assign advance = ~stall;

    assign wb_en   = advance & win_valid[DEPTH-1];
    assign wb_rd   = win_rd[DEPTH-1];
    assign wb_data = upd_data[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid   <= '0;
            win_ready   <= '1;
            stall_count <= '0;
        end else begin
            if (advance) begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    win_valid[i] <= win_valid[i-1];
                    win_ready[i] <= win_ready[i-1] | ld_resp_valid;
                end
                win_valid[0] <= cap_valid;
                win_ready[0] <= ~cap_load;
            end else begin
                win_ready <= win_ready | {DEPTH{ld_resp_valid}};
            end
            if (stall && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    // NOTE: rd/data are qualified by valid/ready, so this payload storage needs no reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                win_rd[i]   <= win_rd[i-1];
                win_data[i] <= upd_data[i-1];
            end
            win_rd[0]   <= ex_rd;
            win_data[0] <= ex_result;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                win_data[i] <= upd_data[i];
            end
        end
    end

endmodule

// File: tb/tb_execute_forward_unit.sv
// Directed bench for execute_forward_unit (DEPTH=3): a vector table for the main
// forwarding/retire/load flow plus hand-written second-load, flush and reset sequences.
module tb_execute_forward_unit;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int DEPTH  = 3;
    localparam int SEL_W  = 2;
    localparam logic [31:0] R1 = 32'hAAAA_0001;
    localparam logic [31:0] R2 = 32'hBBBB_0002;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              ex_valid;
    logic              ex_regwrite;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    logic [XLEN-1:0]   ex_result;
    logic              ld_resp_valid;
    logic [XLEN-1:0]   ld_resp_data;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   src_b;
    logic [SEL_W-1:0]  fwd_sel_a;
    logic [SEL_W-1:0]  fwd_sel_b;
    logic              stall;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic [15:0]       stall_count;

    execute_forward_unit #(
        .XLEN  (XLEN),
        .REG_AW(REG_AW),
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_regwrite  (ex_regwrite),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .ex_result    (ex_result),
        .ld_resp_valid(ld_resp_valid),
        .ld_resp_data (ld_resp_data),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .src_a        (src_a),
        .src_b        (src_b),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall        (stall),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        ex_valid;
        logic        ex_regwrite;
        logic        ex_is_load;
        logic [4:0]  ex_rd;
        logic [31:0] ex_result;
        logic        ld_v;
        logic [31:0] ld_d;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  e_sel_a;
        logic [31:0] e_src_a;
        logic        chk_a;
        logic [1:0]  e_sel_b;
        logic [31:0] e_src_b;
        logic        e_stall;
        logic        e_wb_en;
        logic [4:0]  e_wb_rd;
        logic [31:0] e_wb_data;
        logic [15:0] e_cnt;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        flush         = v.flush;
        ex_valid      = v.ex_valid;
        ex_regwrite   = v.ex_regwrite;
        ex_is_load    = v.ex_is_load;
        ex_rd         = v.ex_rd;
        ex_result     = v.ex_result;
        ld_resp_valid = v.ld_v;
        ld_resp_data  = v.ld_d;
        id_rs1        = v.rs1;
        id_rs2        = v.rs2;
        #1;
        check({tag, " fwd_sel_a"}, 32'(fwd_sel_a), 32'(v.e_sel_a));
        if (v.chk_a) check({tag, " src_a"}, src_a, v.e_src_a);
        check({tag, " fwd_sel_b"}, 32'(fwd_sel_b), 32'(v.e_sel_b));
        check({tag, " src_b"}, src_b, v.e_src_b);
        check({tag, " stall"}, 32'(stall), 32'(v.e_stall));
        check({tag, " wb_en"}, 32'(wb_en), 32'(v.e_wb_en));
        if (v.e_wb_en) begin
            check({tag, " wb_rd"}, 32'(wb_rd), 32'(v.e_wb_rd));
            check({tag, " wb_data"}, wb_data, v.e_wb_data);
        end
        check({tag, " stall_count"}, 32'(stall_count), 32'(v.e_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    vec_t vecs [17];

    initial begin
        // flush, ex_valid, ex_regwrite, ex_is_load, ex_rd, ex_result, ld_v, ld_d, rs1, rs2,
        // sel_a, src_a, chk_a, sel_b, src_b, stall, wb_en, wb_rd, wb_data, stall_count
        vecs[0]  = '{1'b0,1'b1,1'b1,1'b0,5'd5, 32'h10,  1'b0,32'h0,   5'd5, 5'd0,  2'd0,R1,1'b1,        2'd0,R2,     1'b0,1'b0,5'd0, 32'h0,   16'd0};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,5'd5, 32'h11,  1'b0,32'h0,   5'd5, 5'd0,  2'd1,32'h10,1'b1,    2'd0,R2,     1'b0,1'b0,5'd0, 32'h0,   16'd0};
        vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,5'd9, 32'h33,  1'b0,32'h0,   5'd5, 5'd9,  2'd1,32'h11,1'b1,    2'd0,R2,     1'b0,1'b0,5'd0, 32'h0,   16'd0};
        vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,5'd5, 32'h22,  1'b0,32'h0,   5'd9, 5'd5,  2'd1,32'h33,1'b1,    2'd2,32'h11, 1'b0,1'b1,5'd5, 32'h10,  16'd0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,   1'b0,32'h0,   5'd0, 5'd5,  2'd0,R1,1'b1,        2'd1,32'h22, 1'b0,1'b1,5'd5, 32'h11,  16'd0};
        vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,5'd0, 32'h99,  1'b0,32'h0,   5'd0, 5'd9,  2'd0,R1,1'b1,        2'd3,32'h33, 1'b0,1'b1,5'd9, 32'h33,  16'd0};
        vecs[6]  = '{1'b0,1'b1,1'b1,1'b1,5'd7, 32'hDEAD,1'b0,32'h0,   5'd0, 5'd0,  2'd0,R1,1'b1,        2'd0,R2,     1'b0,1'b1,5'd5, 32'h22,  16'd0};
        vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,5'd8, 32'h44,  1'b0,32'h0,   5'd7, 5'd0,  2'd1,32'h0,1'b0,     2'd0,R2,     1'b1,1'b0,5'd0, 32'h0,   16'd0};
        vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,5'd8, 32'h44,  1'b0,32'h0,   5'd7, 5'd0,  2'd1,32'h0,1'b0,     2'd0,R2,     1'b1,1'b0,5'd0, 32'h0,   16'd1};
        vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,5'd8, 32'h44,  1'b1,32'hABCD,5'd7, 5'd0,  2'd1,32'hABCD,1'b1,  2'd0,R2,     1'b0,1'b0,5'd0, 32'h0,   16'd2};
        vecs[10] = '{1'b0,1'b1,1'b1,1'b1,5'd12,32'h0,   1'b0,32'h0,   5'd7, 5'd0,  2'd2,32'hABCD,1'b1,  2'd0,R2,     1'b0,1'b0,5'd0, 32'h0,   16'd2};
        vecs[11] = '{1'b0,1'b1,1'b1,1'b0,5'd13,32'h55,  1'b0,32'h0,   5'd8, 5'd0,  2'd2,32'h44,1'b1,    2'd0,R2,     1'b0,1'b1,5'd7, 32'hABCD,16'd2};
        vecs[12] = '{1'b0,1'b1,1'b1,1'b0,5'd14,32'h66,  1'b0,32'h0,   5'd0, 5'd0,  2'd0,R1,1'b1,        2'd0,R2,     1'b0,1'b1,5'd8, 32'h44,  16'd2};
        vecs[13] = '{1'b0,1'b1,1'b1,1'b0,5'd15,32'h77,  1'b0,32'h0,   5'd0, 5'd0,  2'd0,R1,1'b1,        2'd0,R2,     1'b1,1'b0,5'd0, 32'h0,   16'd2};
        vecs[14] = '{1'b0,1'b1,1'b1,1'b0,5'd15,32'h77,  1'b0,32'h0,   5'd0, 5'd0,  2'd0,R1,1'b1,        2'd0,R2,     1'b1,1'b0,5'd0, 32'h0,   16'd3};
        vecs[15] = '{1'b0,1'b1,1'b1,1'b0,5'd15,32'h77,  1'b1,32'h1234,5'd12,5'd13, 2'd3,32'h1234,1'b1,  2'd2,32'h55, 1'b0,1'b1,5'd12,32'h1234,16'd4};
        vecs[16] = '{1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,   1'b1,32'hFFFF,5'd13,5'd15, 2'd3,32'h55,1'b1,    2'd1,32'h77, 1'b0,1'b1,5'd13,32'h55,  16'd4};

        rst_n         = 1'b0;
        flush         = 1'b0;
        ex_valid      = 1'b0;
        ex_regwrite   = 1'b0;
        ex_is_load    = 1'b0;
        ex_rd         = '0;
        ex_result     = '0;
        ld_resp_valid = 1'b0;
        ld_resp_data  = '0;
        id_rs1        = 5'd5;
        id_rs2        = 5'd6;
        rs1_data      = R1;
        rs2_data      = R2;

        repeat (2) @(negedge clk);
        #1;
        check("reset stall", 32'(stall), 32'd0);
        check("reset wb_en", 32'(wb_en), 32'd0);
        check("reset fwd_sel_a", 32'(fwd_sel_a), 32'd0);
        check("reset fwd_sel_b", 32'(fwd_sel_b), 32'd0);
        check("reset stall_count", 32'(stall_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Second load while one is outstanding, then flushed capture.
        apply('{1'b0,1'b1,1'b1,1'b1,5'd20,32'h0,  1'b0,32'h0,   5'd0, 5'd0, 2'd0,R1,1'b1,       2'd0,R2, 1'b0,1'b1,5'd14,32'h66,  16'd4}, "ld1");
        apply('{1'b0,1'b1,1'b1,1'b1,5'd21,32'h0,  1'b0,32'h0,   5'd0, 5'd0, 2'd0,R1,1'b1,       2'd0,R2, 1'b1,1'b0,5'd0, 32'h0,   16'd4}, "ld2a");
        apply('{1'b0,1'b1,1'b1,1'b1,5'd21,32'h0,  1'b0,32'h0,   5'd0, 5'd0, 2'd0,R1,1'b1,       2'd0,R2, 1'b1,1'b0,5'd0, 32'h0,   16'd5}, "ld2b");
        apply('{1'b0,1'b1,1'b1,1'b1,5'd21,32'h0,  1'b1,32'h2020,5'd0, 5'd0, 2'd0,R1,1'b1,       2'd0,R2, 1'b0,1'b1,5'd15,32'h77,  16'd6}, "ld2resp");
        apply('{1'b1,1'b1,1'b1,1'b0,5'd22,32'h222,1'b0,32'h0,   5'd20,5'd0, 2'd2,32'h2020,1'b1, 2'd0,R2, 1'b0,1'b0,5'd0, 32'h0,   16'd6}, "flush");
        apply('{1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,  1'b0,32'h0,   5'd22,5'd0, 2'd0,R1,1'b1,       2'd0,R2, 1'b0,1'b1,5'd20,32'h2020,16'd6}, "noflushfwd");
        apply('{1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,  1'b0,32'h0,   5'd21,5'd0, 2'd3,32'h0,1'b0,    2'd0,R2, 1'b1,1'b0,5'd0, 32'h0,   16'd6}, "ldwait");

        // Reset asserted mid-stall: outputs return to reset values without a clock edge.
        rst_n = 1'b0;
        #1;
        check("midrst stall", 32'(stall), 32'd0);
        check("midrst wb_en", 32'(wb_en), 32'd0);
        check("midrst fwd_sel_a", 32'(fwd_sel_a), 32'd0);
        check("midrst src_a", src_a, R1);
        check("midrst stall_count", 32'(stall_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // A late response for the dropped load must be ignored.
        apply('{1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,  1'b1,32'h5555,5'd21,5'd21,2'd0,R1,1'b1,       2'd0,R2, 1'b0,1'b0,5'd0, 32'h0,   16'd0}, "lateresp");
        apply('{1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,  1'b0,32'h0,   5'd21,5'd0, 2'd0,R1,1'b1,       2'd0,R2, 1'b0,1'b0,5'd0, 32'h0,   16'd0}, "afterrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
